// File: rtl/addr_map_cfg.sv
// Programmable decoder rule table with a shadow copy and an atomic commit.
// A commit checks each enabled shadow rule, one per cycle, then copies the table to the active outputs.
module addr_map_cfg #(
    parameter int unsigned NoRules   = 4,
    parameter int unsigned NoIndices = 8,
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned IdxWidth  = 4,
    parameter int unsigned SelWidth  = (NoRules > 1) ? $clog2(NoRules) : 1,
    parameter int unsigned RuleWidth = IdxWidth + 2*AddrWidth
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         cfg_req_valid_i,
    output logic                         cfg_req_ready_o,
    input  logic                         cfg_we_i,
    input  logic [SelWidth-1:0]          cfg_sel_i,
    input  logic [1:0]                   cfg_field_i,
    input  logic [AddrWidth-1:0]         cfg_wdata_i,
    output logic                         cfg_rsp_valid_o,
    input  logic                         cfg_rsp_ready_i,
    output logic [AddrWidth-1:0]         cfg_rdata_o,
    output logic                         cfg_err_o,
    output logic [NoRules*RuleWidth-1:0] addr_map_o,
    output logic [NoRules-1:0]           rule_en_o,
    output logic                         map_valid_o,
    output logic                         busy_o
);

    // state    | meaning
    // ST_IDLE  | accepting a request
    // ST_CHECK | validating shadow rules, counter 0..NoRules-1, then one apply cycle
    // ST_RESP  | holding the response until the requester takes it
    typedef enum logic [1:0] {ST_IDLE, ST_CHECK, ST_RESP} state_e;

    localparam logic [SelWidth:0] LastCnt = (SelWidth+1)'(NoRules);

    state_e                state_q, state_d;
    logic [SelWidth:0]     cnt_q, cnt_d;
    logic                  fail_q, fail_d;
    logic [AddrWidth-1:0]  rdata_q, rdata_d;
    logic                  err_q, err_d;

    logic [IdxWidth-1:0]   sh_idx_q   [NoRules];
    logic [AddrWidth-1:0]  sh_start_q [NoRules];
    logic [AddrWidth-1:0]  sh_end_q   [NoRules];
    logic [NoRules-1:0]    sh_en_q;

    logic [IdxWidth-1:0]   act_idx_q   [NoRules];
    logic [AddrWidth-1:0]  act_start_q [NoRules];
    logic [AddrWidth-1:0]  act_end_q   [NoRules];
    logic [NoRules-1:0]    act_en_q;
    logic                  map_valid_q;

    logic                  sel_ok;
    logic                  sh_we;
    logic                  apply;
    logic                  rule_fail;
    logic [SelWidth-1:0]   cnt_sel;

    assign sel_ok  = ({1'b0, cfg_sel_i} < LastCnt);
    assign cnt_sel = cnt_q[SelWidth-1:0];

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        fail_d          = fail_q;
        rdata_d         = rdata_q;
        err_d           = err_q;
        cfg_req_ready_o = 1'b0;
        cfg_rsp_valid_o = 1'b0;
        busy_o          = 1'b0;
        sh_we           = 1'b0;
        apply           = 1'b0;
        rule_fail       = 1'b0;

        if (cnt_q < LastCnt) begin
            rule_fail = sh_en_q[cnt_sel] &&
                        ((sh_start_q[cnt_sel] >= sh_end_q[cnt_sel]) ||
                         (32'(sh_idx_q[cnt_sel]) >= NoIndices));
        end

        case (state_q)
            ST_IDLE: begin
                cfg_req_ready_o = 1'b1;
                if (cfg_req_valid_i) begin
                    state_d = ST_RESP;
                    rdata_d = '0;
                    err_d   = 1'b0;
                    if (cfg_field_i == 2'd3) begin
                        if (cfg_we_i && cfg_wdata_i[0]) begin
                            state_d = ST_CHECK;
                            cnt_d   = '0;
                            fail_d  = 1'b0;
                        end else if (!cfg_we_i) begin
                            rdata_d = AddrWidth'(act_en_q);
                        end
                    end else if (!sel_ok) begin
                        err_d = 1'b1;
                    end else if (cfg_we_i) begin
                        sh_we = 1'b1;
                    end else begin
                        case (cfg_field_i)
                            2'd0: begin
                                rdata_d                = AddrWidth'(sh_idx_q[cfg_sel_i]);
                                rdata_d[AddrWidth-1]   = sh_en_q[cfg_sel_i];
                            end
                            2'd1:    rdata_d = sh_start_q[cfg_sel_i];
                            default: rdata_d = sh_end_q[cfg_sel_i];
                        endcase
                    end
                end
            end
            ST_CHECK: begin
                busy_o = 1'b1;
                // Counter reaching NoRules marks the apply cycle; the sticky flag is complete by then.
                if (cnt_q == LastCnt) begin
                    state_d = ST_RESP;
                    err_d   = fail_q;
                    apply   = !fail_q;
                end else begin
                    fail_d = fail_q | rule_fail;
                    cnt_d  = cnt_q + 1'b1;
                end
            end
            ST_RESP: begin
                cfg_rsp_valid_o = 1'b1;
                if (cfg_rsp_ready_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            fail_q  <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fail_q  <= fail_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned k = 0; k < NoRules; k++) begin
                sh_idx_q[k]   <= '0;
                sh_start_q[k] <= '0;
                sh_end_q[k]   <= '0;
            end
            sh_en_q <= '0;
        end else if (sh_we) begin
            case (cfg_field_i)
                2'd0: begin
                    sh_idx_q[cfg_sel_i] <= cfg_wdata_i[IdxWidth-1:0];
                    sh_en_q[cfg_sel_i]  <= cfg_wdata_i[AddrWidth-1];
                end
                2'd1:    sh_start_q[cfg_sel_i] <= cfg_wdata_i;
                default: sh_end_q[cfg_sel_i]   <= cfg_wdata_i;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned k = 0; k < NoRules; k++) begin
                act_idx_q[k]   <= '0;
                act_start_q[k] <= '0;
                act_end_q[k]   <= '0;
            end
            act_en_q    <= '0;
            map_valid_q <= 1'b0;
        end else if (apply) begin
            for (int unsigned k = 0; k < NoRules; k++) begin
                act_idx_q[k]   <= sh_idx_q[k];
                act_start_q[k] <= sh_start_q[k];
                act_end_q[k]   <= sh_end_q[k];
            end
            act_en_q    <= sh_en_q;
            map_valid_q <= 1'b1;
        end
    end

    always_comb begin
        addr_map_o = '0;
        for (int unsigned k = 0; k < NoRules; k++) begin
            addr_map_o[k*RuleWidth +: RuleWidth] = {act_idx_q[k], act_start_q[k], act_end_q[k]};
        end
    end

    assign rule_en_o   = act_en_q;
    assign map_valid_o = map_valid_q;
    assign cfg_rdata_o = rdata_q;
    assign cfg_err_o   = err_q;

endmodule

// File: tb/tb_addr_map_cfg.sv
// Scoreboard bench for addr_map_cfg: a rule-table model predicts every response and the active map.
module tb_addr_map_cfg;

    localparam int NR = 4;
    localparam int NI = 8;
    localparam int AW = 32;
    localparam int IW = 4;
    localparam int SW = 2;
    localparam int RW = IW + 2*AW;
    localparam int MW = NR*RW;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           req_valid;
    logic           req_ready;
    logic           we;
    logic [SW-1:0]  sel;
    logic [1:0]     field;
    logic [AW-1:0]  wdata;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [AW-1:0]  rdata;
    logic           err;
    logic [MW-1:0]  addr_map;
    logic [NR-1:0]  rule_en;
    logic           map_valid;
    logic           busy;

    always #5 clk = ~clk;

    addr_map_cfg #(.NoRules(NR), .NoIndices(NI), .AddrWidth(AW), .IdxWidth(IW)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .cfg_req_valid_i(req_valid), .cfg_req_ready_o(req_ready),
        .cfg_we_i(we), .cfg_sel_i(sel), .cfg_field_i(field), .cfg_wdata_i(wdata),
        .cfg_rsp_valid_o(rsp_valid), .cfg_rsp_ready_i(rsp_ready),
        .cfg_rdata_o(rdata), .cfg_err_o(err),
        .addr_map_o(addr_map), .rule_en_o(rule_en),
        .map_valid_o(map_valid), .busy_o(busy)
    );

    typedef struct {
        logic [AW-1:0] rdata;
        logic          err;
        logic [MW-1:0] map;
        logic [NR-1:0] en;
        logic          mv;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference rule table: shadow and active copies as plain integers.
    int unsigned m_idx[NR], m_start[NR], m_end[NR];
    bit          m_en[NR];
    int unsigned a_idx[NR], a_start[NR], a_end[NR];
    bit          a_en[NR];
    bit          a_mv;

    task automatic chk(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [MW-1:0] model_map();
        logic [MW-1:0] m;
        m = '0;
        for (int k = 0; k < NR; k++)
            m[k*RW +: RW] = {IW'(a_idx[k]), AW'(a_start[k]), AW'(a_end[k])};
        return m;
    endfunction

    function automatic logic [NR-1:0] model_en();
        logic [NR-1:0] e;
        for (int k = 0; k < NR; k++) e[k] = a_en[k];
        return e;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NR; k++) begin
            m_idx[k] = 0; m_start[k] = 0; m_end[k] = 0; m_en[k] = 0;
            a_idx[k] = 0; a_start[k] = 0; a_end[k] = 0; a_en[k] = 0;
        end
        a_mv = 0;
    endtask

    // Apply one request to the model and queue the response it should produce.
    task automatic model_req(input logic w, input int s, input int f, input logic [AW-1:0] d);
        exp_t e;
        bit ok;
        e.rdata = '0;
        e.err   = 1'b0;
        if (f == 3) begin
            if (w && d[0]) begin
                ok = 1;
                for (int k = 0; k < NR; k++)
                    if (m_en[k] && !(m_start[k] < m_end[k] && m_idx[k] < NI)) ok = 0;
                e.err = !ok;
                if (ok) begin
                    for (int k = 0; k < NR; k++) begin
                        a_idx[k] = m_idx[k]; a_start[k] = m_start[k];
                        a_end[k] = m_end[k]; a_en[k] = m_en[k];
                    end
                    a_mv = 1;
                end
            end else if (!w) begin
                e.rdata = AW'(model_en());
            end
        end else if (s >= NR) begin
            e.err = 1'b1;
        end else if (w) begin
            if (f == 0) begin
                m_idx[s] = d % (1 << IW);
                m_en[s]  = d[AW-1];
            end else if (f == 1) m_start[s] = d;
            else m_end[s] = d;
        end else begin
            if (f == 0) e.rdata = (AW'(m_en[s]) << (AW-1)) | AW'(m_idx[s]);
            else if (f == 1) e.rdata = m_start[s];
            else e.rdata = m_end[s];
        end
        e.map = model_map();
        e.en  = model_en();
        e.mv  = a_mv;
        sb.push_back(e);
    endtask

    // Monitor: compares each response at the handshake.
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_rsp", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rsp_rdata", rdata, e.rdata);
                chk("rsp_err", err, e.err);
                chk("addr_map", addr_map, e.map);
                chk("rule_en", rule_en, e.en);
                chk("map_valid", map_valid, e.mv);
            end
        end
    end

    task automatic issue(input logic w, input int s, input int f, input logic [AW-1:0] d);
        int guard;
        model_req(w, s, f, d);
        guard = 0;
        while (!req_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 50) chk("req_ready_timeout", 0, 1);
        req_valid = 1'b1; we = w; sel = SW'(s); field = 2'(f); wdata = d;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic finish_rsp();
        int guard;
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        rsp_ready = 1'b1;
        guard = 0;
        while (sb.size() != 0 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 50) chk("rsp_timeout", 0, 1);
        rsp_ready = 1'b0;
    endtask

    task automatic do_req(input logic w, input int s, input int f, input logic [AW-1:0] d);
        issue(w, s, f, d);
        finish_rsp();
    endtask

    // Commit with latency and atomicity checks: nothing visible until NoRules+1 edges after acceptance.
    task automatic do_commit();
        logic [MW-1:0] old_map;
        logic [NR-1:0] old_en;
        logic          old_mv;
        old_map = model_map();
        old_en  = model_en();
        old_mv  = a_mv;
        issue(1'b1, $urandom_range(0, NR-1), 3, 32'h1);
        for (int i = 1; i <= NR+1; i++) begin
            if (i <= NR) begin
                chk("commit_busy", busy, 1);
                chk("commit_no_rsp_yet", rsp_valid, 0);
                chk("commit_map_held", addr_map, old_map);
                chk("commit_en_held", rule_en, old_en);
                chk("commit_mv_held", map_valid, old_mv);
                chk("commit_req_blocked", req_ready, 0);
            end
            @(posedge clk); #1;
        end
        chk("commit_rsp_latency", rsp_valid, 1);
        chk("commit_busy_done", busy, 0);
        finish_rsp();
    endtask

    initial begin
        logic [AW-1:0] d;
        int op;
        rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
        we = 1'b0; sel = '0; field = '0; wdata = '0;
        model_reset();

        repeat (3) begin @(posedge clk); #1; end
        chk("rst_map", addr_map, '0);
        chk("rst_en", rule_en, '0);
        chk("rst_mv", map_valid, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rdata", rdata, '0);
        chk("rst_err", err, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_req_ready", req_ready, 1);

        // Rule 0 {en, idx=2, 0x1000..0x2000}, read-back, commit.
        do_req(1, 0, 0, 32'h8000_0002);
        do_req(1, 0, 1, 32'h0000_1000);
        do_req(1, 0, 2, 32'h0000_2000);
        do_req(0, 0, 0, '0);
        do_commit();

        // Empty range on rule 1 must be rejected.
        do_req(1, 1, 0, 32'h8000_0001);
        do_req(1, 1, 1, 32'h0000_3000);
        do_req(1, 1, 2, 32'h0000_3000);
        do_commit();

        // Out-of-range index rejected when enabled, ignored when disabled.
        do_req(1, 1, 2, 32'h0000_4000);
        do_req(1, 2, 1, 32'h0000_5000);
        do_req(1, 2, 2, 32'h0000_6000);
        do_req(1, 2, 0, 32'h8000_0008);
        do_commit();
        do_req(1, 2, 0, 32'h0000_0008);
        do_commit();

        do_req(1, 0, 3, 32'h0000_0000);
        do_req(0, 3, 3, '0);

        // Response backpressure: response held stable, no new request accepted.
        issue(0, 0, 1, '0);
        for (int i = 0; i < 5; i++) begin
            chk("bp_rsp_valid", rsp_valid, 1);
            chk("bp_rdata", rdata, sb[0].rdata);
            chk("bp_req_ready", req_ready, 0);
            @(posedge clk); #1;
        end
        finish_rsp();

        for (int n = 0; n < 300; n++) begin
            op = $urandom_range(0, 11);
            if (op == 0) begin
                do_commit();
            end else if (op == 1) begin
                do_req($urandom_range(0, 1), $urandom_range(0, NR-1), 3, 32'h0);
            end else begin
                field = 2'($urandom_range(0, 2));
                if (field == 0) begin
                    d = $urandom;
                    d[IW-1:0] = IW'($urandom_range(0, 9));
                    d[AW-1] = ($urandom_range(0, 3) != 0);
                end else begin
                    d = $urandom_range(0, 32'h8000);
                end
                do_req($urandom_range(0, 2) != 0, $urandom_range(0, NR-1), int'(field), d);
            end
        end

        // Reset during a commit abandons it and clears everything.
        do_req(1, 3, 0, 32'h8000_0003);
        do_req(1, 3, 1, 32'h0000_0100);
        do_req(1, 3, 2, 32'h0000_0200);
        do_req(1, 0, 0, 32'h0000_0000);
        do_req(1, 1, 0, 32'h0000_0000);
        do_req(1, 2, 0, 32'h0000_0000);
        do_commit();
        issue(1, 0, 3, 32'h1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("midcommit_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        sb.delete();
        model_reset();
        chk("midrst_map", addr_map, '0);
        chk("midrst_en", rule_en, '0);
        chk("midrst_mv", map_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_rsp_valid", rsp_valid, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("midrst_req_ready", req_ready, 1);
        do_req(0, 3, 0, '0);
        do_req(0, 0, 3, '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
